// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction-fetch sequencer: PC, imem handshake, IF/ID register
//
// Purpose:
//   Owns the program counter and drives a combinational request/ready
//   handshake to instruction memory. Fetched words are written into the
//   IF/ID pipeline register together with their next-PC and a valid bit.
//   A one-entry skid buffer catches a word that arrives while ID is
//   stalled. Branch redirects from EX/MEM flush IF/ID and restart fetch.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   EX_MEM_PCSrc      branch taken; redirect PC to EX_MEM_NPC
//   EX_MEM_NPC        branch target
//   stall             hazard unit holds IF/ID
//   imem_req          fetch request
//   imem_addr         fetch address, always equal to pc
//   imem_ready        imem_data valid for imem_addr this cycle
//   imem_data         fetched instruction
//   IF_ID_instr       IF/ID instruction register
//   IF_ID_npc         IF/ID next-PC register
//   IF_ID_valid       IF/ID holds a real instruction
//   pc                current PC
//   fetch_count       instructions delivered to IF/ID, saturating

module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_MEM_PCSrc,
  input  logic [31:0]      EX_MEM_NPC,
  input  logic             stall,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_data,
  output logic [31:0]      IF_ID_instr,
  output logic [31:0]      IF_ID_npc,
  output logic             IF_ID_valid,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] LP_STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_npc;
  logic             r_valid;
  logic [31:0]      r_skid_instr;
  logic [31:0]      r_skid_npc;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [31:0]      w_pc_nxt;
  logic [31:0]      w_instr_nxt;
  logic [31:0]      w_npc_nxt;
  logic             w_valid_nxt;
  logic [31:0]      w_skid_instr_nxt;
  logic [31:0]      w_skid_npc_nxt;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_pc_plus;

  // Modulo-2^32 add: all-ones PC wraps to zero naturally.
  assign w_pc_plus = r_pc + LP_STEP;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_npc_nxt        = r_npc;
    w_valid_nxt      = r_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_npc_nxt   = r_skid_npc;
    w_cnt_inc        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ready && !stall) begin
          w_instr_nxt = imem_data;
          w_npc_nxt   = w_pc_plus;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_plus;
          w_cnt_inc   = 1'b1;
        end else if (imem_ready && stall) begin
          // ID cannot take the word; park it so the fetch is not wasted.
          w_skid_instr_nxt = imem_data;
          w_skid_npc_nxt   = w_pc_plus;
          w_pc_nxt         = w_pc_plus;
          w_state_nxt      = S_HOLD;
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
        end
      end

      S_HOLD: begin
        if (!stall) begin
          w_instr_nxt = r_skid_instr;
          w_npc_nxt   = r_skid_npc;
          w_valid_nxt = 1'b1;
          w_cnt_inc   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Redirect overrides everything above, including stall: any word
    // returned this cycle and any parked skid word belong to the wrong path.
    if (EX_MEM_PCSrc) begin
      w_pc_nxt         = EX_MEM_NPC;
      w_instr_nxt      = r_instr;
      w_npc_nxt        = r_npc;
      w_valid_nxt      = 1'b0;
      w_skid_instr_nxt = r_skid_instr;
      w_skid_npc_nxt   = r_skid_npc;
      w_cnt_inc        = 1'b0;
      w_state_nxt      = S_FETCH;
    end
  end

  // Saturating delivery counter.
  assign w_cnt_nxt = (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= 32'd0;
      r_npc        <= 32'd0;
      r_valid      <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_npc   <= 32'd0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_npc        <= w_npc_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_npc   <= w_skid_npc_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign IF_ID_instr = r_instr;
  assign IF_ID_npc   = r_npc;
  assign IF_ID_valid = r_valid;
  assign fetch_count = r_cnt;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl against a behavioural model

module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MEM_PCSrc;
  logic [31:0] EX_MEM_NPC;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        IF_ID_valid;
  logic [31:0] pc;
  logic [15:0] fetch_count;

  logic [31:0] salt;

  always #5 clk = ~clk;

  // Memory image: word at address a is a*3 + salt.
  assign imem_data = imem_addr * 32'd3 + salt;

  ifetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (1),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .EX_MEM_NPC  (EX_MEM_NPC),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .IF_ID_instr (IF_ID_instr),
    .IF_ID_npc   (IF_ID_npc),
    .IF_ID_valid (IF_ID_valid),
    .pc          (pc),
    .fetch_count (fetch_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what the fetch stage has promised, not how it is built.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;
  int          m_count;
  bit          m_idle;         // first cycle after reset: no request yet
  logic [31:0] m_parked[$];    // word fetched while ID was stalled
  logic [31:0] m_parked_npc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + salt;
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_npc   = 32'h0;
    m_valid = 1'b0;
    m_count = 0;
    m_idle  = 1'b1;
    m_parked.delete();
    m_parked_npc = 32'h0;
  endtask

  task automatic deliver(input logic [31:0] instr, input logic [31:0] npc);
    m_instr = instr;
    m_npc   = npc;
    m_valid = 1'b1;
    if (m_count < 65535) m_count = m_count + 1;
  endtask

  task automatic model_step(input logic p, input logic [31:0] n, input logic s, input logic r);
    if (p) begin
      m_pc    = n;
      m_valid = 1'b0;
      m_idle  = 1'b0;
      m_parked.delete();
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_parked.size() != 0) begin
      if (!s) deliver(m_parked.pop_front(), m_parked_npc);
    end else if (r && !s) begin
      deliver(mem_word(m_pc), m_pc + 32'd1);
      m_pc = m_pc + 32'd1;
    end else if (r && s) begin
      m_parked.push_back(mem_word(m_pc));
      m_parked_npc = m_pc + 32'd1;
      m_pc = m_pc + 32'd1;
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic exp_req;
    exp_req = !m_idle && (m_parked.size() == 0);
    chk({tag, ".pc"},    pc,                  m_pc);
    chk({tag, ".addr"},  imem_addr,           m_pc);
    chk({tag, ".req"},   {31'd0, imem_req},   {31'd0, exp_req});
    chk({tag, ".instr"}, IF_ID_instr,         m_instr);
    chk({tag, ".npc"},   IF_ID_npc,           m_npc);
    chk({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, m_valid});
    chk({tag, ".count"}, {16'd0, fetch_count}, 32'(m_count));
  endtask

  // Called at posedge+1; drives inputs, advances one clock, checks at posedge+1.
  task automatic step(input string tag, input logic p, input logic [31:0] n,
                      input logic s, input logic r, input bit do_chk);
    EX_MEM_PCSrc = p;
    EX_MEM_NPC   = n;
    stall        = s;
    imem_ready   = r;
    model_step(p, n, s, r);
    @(posedge clk);
    #1;
    if (do_chk) chk_all(tag);
  endtask

  // Called at posedge+1; asserts reset between edges and releases it after one edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    @(posedge clk);
    #1;
    chk_all({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    EX_MEM_PCSrc = 1'b0;
    EX_MEM_NPC   = 32'h0;
    stall        = 1'b0;
    imem_ready   = 1'b0;
    salt         = 32'h0;
    #1;
    model_reset();
    chk_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Always-ready memory: one IDLE cycle, then one instruction per cycle.
    step("t1_idle", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t1_idle_valid", {31'd0, IF_ID_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("t1_fetch", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("t1_instr", IF_ID_instr, 32'(i * 3));
      chk("t1_npc",   IF_ID_npc,   32'(i + 1));
    end
    chk("t1_count", {16'd0, fetch_count}, 32'd3);

    // Memory ready every third cycle: valid pattern 0,0,1.
    for (int i = 0; i < 9; i++) begin
      step("t2", 1'b0, 32'h0, 1'b0, (i % 3) == 2, 1'b1);
      chk("t2_valid", {31'd0, IF_ID_valid}, {31'd0, (i % 3) == 2});
    end

    // Stall for 4 cycles with memory ready at pc=5.
    step("t3_redir", 1'b1, 32'h5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step("t3_hold", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("t3_pc",  pc, 32'h6);
      chk("t3_req", {31'd0, imem_req}, 32'd0);
    end
    step("t3_release", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t3_instr", IF_ID_instr, 32'd15);
    chk("t3_npc",   IF_ID_npc,   32'd6);
    step("t3_resume", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t3_resume_npc", IF_ID_npc, 32'd7);

    // Redirect with ready and stall in the same cycle.
    step("t4_redir", 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    chk("t4_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("t4_pc",    pc, 32'h40);
    step("t4_next", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t4_npc",   IF_ID_npc, 32'h41);

    // PC wrap at all-ones.
    step("t5_redir", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step("t5_wrap",  1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t5_npc", IF_ID_npc, 32'h0);
    chk("t5_pc",  pc,        32'h0);

    // Asynchronous reset while parked in HOLD.
    step("t6_park", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step("t6_hold", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    async_reset("t6_rst");
    step("t6_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t6_no_phantom", {31'd0, IF_ID_valid}, 32'd0);
    step("t6_first", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t6_first_npc", IF_ID_npc, 32'd1);

    // Randomized traffic.
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 15) == 0,
           $urandom,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           1'b1);
    end

    // Counter saturation.
    salt = 32'h0;
    async_reset("t7_rst");
    step("t7_idle", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      step("t7_run", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    chk_all("t7_pre");
    chk("t7_fffe", {16'd0, fetch_count}, 32'h0000_FFFE);
    step("t7_max", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t7_ffff", {16'd0, fetch_count}, 32'h0000_FFFF);
    step("t7_sat", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t7_sat_hold", {16'd0, fetch_count}, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
